// File: rtl/arcade_input_hub.sv
// arcade_input_hub: merges USB, DB9 and PS/2 inputs into per-player controls,
// applies rotation and autofire, and shapes a single coin pulse.
module arcade_input_hub #(
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned BUTTONS    = 2,
  parameter logic [23:0] COIN_PULSE = 24'd600000,
  parameter logic [19:0] AF_DIV     = 20'd400000
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic [10:0]                ps2_key,
  input  logic [16*PLAYERS-1:0]      joy_usb,
  input  logic [16*PLAYERS-1:0]      joy_db9,
  input  logic [PLAYERS-1:0]         db9_en,
  input  logic                       rotate,
  input  logic [PLAYERS-1:0]         autofire_en,
  output logic [4*PLAYERS-1:0]       p_dir,
  output logic [BUTTONS*PLAYERS-1:0] p_btn,
  output logic [PLAYERS-1:0]         p_start,
  output logic                       coin
);

  localparam int unsigned DW    = 4 * PLAYERS;
  localparam int unsigned BW    = BUTTONS * PLAYERS;
  localparam int unsigned NKEYS = 18;
  localparam logic [2:0]  BMASK = 3'((1 << BUTTONS) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  logic             toggle_q;
  logic [NKEYS-1:0] keys_q;
  logic [NKEYS-1:0] key_hit;
  logic             ps2_event;

  logic [DW-1:0]      dir_d;
  logic [BW-1:0]      btn_d;
  logic [PLAYERS-1:0] start_d;
  logic               req;
  logic               req_d;

  logic [15:0] usb_w;
  logic [15:0] db9_w;
  logic [3:0]  pad_dir;
  logic [3:0]  kb_dir;
  logic [3:0]  m_dir;
  logic [2:0]  pad_btn;
  logic [2:0]  kb_btn;
  logic [2:0]  m_btn;
  logic        pad_start;
  logic        pad_coin;
  logic        kb_start;
  logic        sel_db9;

  logic [19:0] af_cnt;
  logic        af;

  coin_state_t state_q;
  coin_state_t state_d;
  logic [23:0] cnt_q;
  logic [23:0] cnt_d;
  logic        coin_d;

  // Reserved pad bits carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{joy_usb, joy_db9};

  // Scancode decode to one-hot key slot; unmatched codes hit nothing.
  always_comb begin
    key_hit = '0;
    case (ps2_key[8:0])
      9'h175:         key_hit[0]  = 1'b1;  // P0 U
      9'h172:         key_hit[1]  = 1'b1;  // P0 D
      9'h16B:         key_hit[2]  = 1'b1;  // P0 L
      9'h174:         key_hit[3]  = 1'b1;  // P0 R
      9'h029:         key_hit[4]  = 1'b1;  // P0 button 0
      9'h014, 9'h114: key_hit[5]  = 1'b1;  // P0 button 1 (either ctrl)
      9'h02D:         key_hit[6]  = 1'b1;  // P1 U
      9'h02B:         key_hit[7]  = 1'b1;  // P1 D
      9'h023:         key_hit[8]  = 1'b1;  // P1 L
      9'h034:         key_hit[9]  = 1'b1;  // P1 R
      9'h01C:         key_hit[10] = 1'b1;  // P1 button 0
      9'h01B:         key_hit[11] = 1'b1;  // P1 button 1
      9'h016:         key_hit[12] = 1'b1;  // start 0
      9'h005:         key_hit[13] = 1'b1;  // start 0
      9'h01E:         key_hit[14] = 1'b1;  // start 1
      9'h006:         key_hit[15] = 1'b1;  // start 1
      9'h02E:         key_hit[16] = 1'b1;  // coin
      9'h036:         key_hit[17] = 1'b1;  // coin
      default:        ;
    endcase
  end

  assign ps2_event = ps2_key[10] ^ toggle_q;

  // Toggle tracking and key state; reset reloads the toggle so release is silent.
  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_key[10];
    if (!reset_n) begin
      keys_q <= '0;
    end else if (ps2_event) begin
      keys_q <= (keys_q & ~key_hit) | (key_hit & {NKEYS{ps2_key[9]}});
    end
  end

  // Per-player source select, keyboard merge, rotation, autofire and coin request.
  always_comb begin
    dir_d     = '0;
    btn_d     = '0;
    start_d   = '0;
    req       = keys_q[16] | keys_q[17];
    usb_w     = '0;
    db9_w     = '0;
    pad_dir   = '0;
    pad_btn   = '0;
    pad_start = 1'b0;
    pad_coin  = 1'b0;
    kb_dir    = '0;
    kb_btn    = '0;
    kb_start  = 1'b0;
    m_dir     = '0;
    m_btn     = '0;
    sel_db9   = 1'b0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      usb_w   = 16'(joy_usb >> (16 * p));
      db9_w   = 16'(joy_db9 >> (16 * p));
      sel_db9 = 1'(db9_en >> p);
      if (sel_db9) begin
        pad_dir   = db9_w[3:0];
        pad_btn   = {db9_w[5], db9_w[4], db9_w[6]};
        pad_start = db9_w[7] & ~db9_w[4];
        pad_coin  = db9_w[8] | (db9_w[7] & db9_w[4]);
      end else begin
        pad_dir   = usb_w[3:0];
        pad_btn   = 3'(usb_w >> 4);
        pad_start = 1'(usb_w >> (4 + BUTTONS));
        pad_coin  = 1'(usb_w >> (5 + BUTTONS));
      end
      if (p == 0) begin
        kb_dir   = {keys_q[0], keys_q[1], keys_q[2], keys_q[3]};
        kb_btn   = {1'b0, keys_q[5], keys_q[4]};
        kb_start = keys_q[12] | keys_q[13];
      end else if (p == 1) begin
        kb_dir   = {keys_q[6], keys_q[7], keys_q[8], keys_q[9]};
        kb_btn   = {1'b0, keys_q[11], keys_q[10]};
        kb_start = keys_q[14] | keys_q[15];
      end else begin
        kb_dir   = '0;
        kb_btn   = '0;
        kb_start = 1'b0;
      end
      m_dir = pad_dir | kb_dir;
      if (rotate) begin
        m_dir = {m_dir[1], m_dir[0], m_dir[2], m_dir[3]};
      end
      m_btn = pad_btn | kb_btn;
      if (1'(autofire_en >> p)) begin
        m_btn[0] = m_btn[0] & af;
      end
      dir_d   = dir_d | (DW'(m_dir) << (4 * p));
      btn_d   = btn_d | (BW'(m_btn & BMASK) << (BUTTONS * p));
      start_d = start_d | (PLAYERS'(pad_start | kb_start) << p);
      req     = req | pad_coin;
    end
  end

  // Registered player outputs.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      p_dir   <= '0;
      p_btn   <= '0;
      p_start <= '0;
    end else begin
      p_dir   <= dir_d;
      p_btn   <= btn_d;
      p_start <= start_d;
    end
  end

  // Free-running autofire phase, toggling every AF_DIV cycles.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      af_cnt <= '0;
      af     <= 1'b0;
    end else if (af_cnt == AF_DIV - 20'd1) begin
      af_cnt <= '0;
      af     <= ~af;
    end else begin
      af_cnt <= af_cnt + 20'd1;
    end
  end

  // Coin FSM state; req_d follows the request through reset so a held coin cannot retrigger.
  always_ff @(posedge clk_sys) begin
    req_d <= req;
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coin    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coin    <= coin_d;
    end
  end

  // Coin FSM next state: edge starts a pulse, then an equal-length lockout gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coin_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req & ~req_d) begin
          state_d = PULSE;
          cnt_d   = '0;
          coin_d  = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == COIN_PULSE - 24'd1) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 24'd1;
          coin_d = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == COIN_PULSE - 24'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
